// File: rtl/tune_pkg.sv
// tune_pkg: frame geometry, FSM encoding and byte-extract helper shared by
// tune and tune_spi_loader.
package tune_pkg;
  localparam int FRAME_BITS = 88;
  localparam int NOTE_W     = 8;
  localparam int NUM_NOTES  = 6;
  localparam int SPEED_W    = 36;
  localparam int CNT_W      = 7;

  // Bit counter values: exact frame length, and the saturating overflow mark.
  localparam logic [CNT_W-1:0] CNT_FULL = 7'd88;
  localparam logic [CNT_W-1:0] CNT_SAT  = 7'd89;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  // Byte idx of the frame, byte 0 being the first (most significant) received.
  function automatic logic [NOTE_W-1:0] note_byte(input logic [FRAME_BITS-1:0] f,
                                                  input int idx);
    return f[FRAME_BITS-1-NOTE_W*idx -: NOTE_W];
  endfunction
endpackage

// File: rtl/tune_spi_loader_sync_edge.sv
// sync_edge: SYNC_STAGES-deep synchronizer followed by a registered copy of
// the synchronized level, giving one-cycle rise/fall strobes.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw pin through the chain; remember last synchronized level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Chain and edge-detect registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;
endmodule

// File: rtl/tune_spi_loader.sv
// tune_spi_loader: SPI mode-0 slave that assembles an 88-bit song-setup frame
// and commits note bytes, clock_speed and start to tune atomically.
// Optional feature: define TUNE_SPI_ECHO_EN to echo the frame on sdo, 8 bits late.
module tune_spi_loader import tune_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sck,
  input  logic               sdi,
  input  logic               cs_n,
  output logic               sdo,
  output logic [NOTE_W-1:0]  sd0,
  output logic [NOTE_W-1:0]  sd1,
  output logic [NOTE_W-1:0]  sd2,
  output logic [NOTE_W-1:0]  sd3,
  output logic [NOTE_W-1:0]  sd4,
  output logic [NOTE_W-1:0]  sd5,
  output logic [SPEED_W-1:0] clock_speed,
  output logic               start,
  output logic               frame_err
);
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .reset_n(reset_n), .d(sck), .rise(sck_rise), .fall(sck_fall));

  // cs_n idles high, so its chain resets high to avoid a phantom edge.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset_n(reset_n), .d(cs_n), .rise(cs_rise), .fall(cs_fall));

  // sdi only needs the level, delayed to line up with the sck strobes.
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sdi_s;
  assign sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]            shreg_q, shreg_d;
  logic [NUM_NOTES-1:0][NOTE_W-1:0] sd_q, sd_d;
  logic [SPEED_W-1:0]               speed_q, speed_d;
  logic                             start_q, start_d;
  logic                             err_pend_q, err_pend_d;
  logic                             frame_err_q, frame_err_d;

  // Frame FSM: cs_n edges take priority over sck edges; outputs load only in COMMIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    sd_d        = sd_q;
    speed_d     = speed_q;
    start_d     = start_q;
    err_pend_d  = 1'b0;
    frame_err_d = err_pend_q;  // extra stage aligns the pulse with a commit
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          shreg_d = '0;
          cnt_d   = '0;
          start_d = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (cnt_q == CNT_FULL) begin
            state_d = COMMIT;
          end else begin
            state_d    = IDLE;
            err_pend_d = 1'b1;
          end
        end else if (sck_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 7'd1;
        end
      end
      COMMIT: begin
        for (int i = 0; i < NUM_NOTES; i++) sd_d[i] = note_byte(shreg_q, i);
        speed_d = shreg_q[SPEED_W-1:0];
        start_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      sd_q        <= '0;
      speed_q     <= '0;
      start_q     <= 1'b0;
      err_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
      sdi_sync_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      sd_q        <= sd_d;
      speed_q     <= speed_d;
      start_q     <= start_d;
      err_pend_q  <= err_pend_d;
      frame_err_q <= frame_err_d;
      sdi_sync_q  <= sdi_sync_d;
    end
  end

`ifdef TUNE_SPI_ECHO_EN
  logic sdo_q, sdo_d;

  // Echo: after k bits received, bit k-8 sits at shreg[7]; present it on sck fall.
  always_comb begin
    sdo_d = sdo_q;
    if (state_q == IDLE && cs_fall)                            sdo_d = 1'b0;
    else if (state_q == SHIFT && !cs_rise && sck_fall)         sdo_d = shreg_q[NOTE_W-1];
  end

  // Echo output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sdo_q <= 1'b0;
    else          sdo_q <= sdo_d;
  end

  assign sdo = sdo_q;
`else
  // Falling-edge strobe only feeds the echo path.
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
  assign sdo = 1'b0;
`endif

  assign sd0         = sd_q[0];
  assign sd1         = sd_q[1];
  assign sd2         = sd_q[2];
  assign sd3         = sd_q[3];
  assign sd4         = sd_q[4];
  assign sd5         = sd_q[5];
  assign clock_speed = speed_q;
  assign start       = start_q;
  assign frame_err   = frame_err_q;
endmodule

// File: doc/tune_spi_loader.md
# tune_spi_loader

SPI slave that receives a song-setup frame from the microcontroller and drives the six note bytes, the 36-bit clock-speed word and the `start` level into `tune`, which plays the notes on `pwm`. It is the MCU-facing end of the `tune` control interface. It samples the SPI pins in the `clk` domain, assembles an 88-bit frame, validates its length and commits it atomically. `start` asserts only after a complete, valid frame.

## Interface

- `SYNC_STAGES`, 2, flip-flop depth of the input synchronizers for `sck`, `sdi` and `cs_n` (minimum 2).
- `clk`  in  1  system clock; must run at least 8× the `sck` frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sck`  in  1  SPI clock, mode 0: sample on rising edge, shift on falling edge.
- `sdi`  in  1  SPI data from MCU, MSB first.
- `cs_n`  in  1  SPI chip select, active low; framing signal.
- `sdo`  out  1  SPI data to MCU.
- `sd0`…`sd5`  out  8 each  note bytes to `tune`.
- `clock_speed`  out  36  tempo/clock-division word to `tune`.
- `start`  out  1  level; high while a valid committed frame is being played.
- `frame_err`  out  1  one-cycle pulse on a rejected frame.

## Operation

- Frame: 11 bytes, 88 bits, MSB first. Bytes 0–5 → `sd0`…`sd5`. Bytes 6–10 → `clock_speed`. The upper nibble of byte 6 is discarded, so `clock_speed` = frame bits [35:0].
- FSM states:
  - IDLE → SHIFT on synchronized `cs_n` falling edge. The same cycle clears the shift register and bit counter and drops `start`.
  - SHIFT: each synchronized `sck` rising edge shifts `sdi` into the 88-bit shift register and increments the 7-bit bit counter. The counter saturates at 89, which means overflow.
  - SHIFT → COMMIT on `cs_n` rising edge with count == 88.
  - SHIFT → IDLE on `cs_n` rising edge with count ≠ 88 (short or long frame). This pulses `frame_err`; outputs and `start` are unchanged, so `start` stays low.
  - COMMIT, one cycle: load all output registers from the shift register, set `start` = 1, then go to IDLE.
- Output registers change only in COMMIT; `tune` never sees a partial frame.
- `start` stays high until the next `cs_n` falling edge. A new frame therefore always stops playback first, and restarts it only if that frame is valid.
- Priority: a `cs_n` edge and an `sck` edge in the same cycle → the `cs_n` edge wins and the `sck` edge is ignored.
- `sck` edges while `cs_n` is high are ignored.
- Reset (any time, including mid-frame): FSM → IDLE, counter = 0, shift register = 0, all outputs 0 (`sdo`, `sd0`…`sd5`, `clock_speed`, `start`, `frame_err`).

## Timing

- Input-to-internal latency: `SYNC_STAGES` + 1 cycles (synchronizer plus edge-detect register).
- Commit: outputs and `start` update `SYNC_STAGES` + 2 `clk` cycles after the physical `cs_n` rise.
- `frame_err`: exactly one cycle wide, at the same cycle offset as a commit.
- Minimum `cs_n` high time between frames: `SYNC_STAGES` + 3 `clk` cycles.
- `sdo` changes only on synchronized `sck` falling edges or `cs_n` falling edge; it is held stable across `sck` rising edges.

## Configuration

- `TUNE_SPI_ECHO_EN` defined:
  - `sdo` returns the frame delayed by 8 bits: byte n is echoed during byte n+1.
  - The first byte echoed is 0x00; byte 10 is never echoed.
  - Lets the MCU verify the link.
- Not defined: `sdo` is tied to 0 and the echo register is not built.

## Structure

- `tune_pkg`:
  - `FRAME_BITS` = 88, `NOTE_W` = 8, `NUM_NOTES` = 6, `SPEED_W` = 36.
  - FSM state enum `{IDLE, SHIFT, COMMIT}`.
  - Shared by `tune` and this block.
- Sub-module `sync_edge`, parameterized by `SYNC_STAGES`:
  - multi-flop synchronizer plus registered rise/fall detect.
  - Instantiated for `sck` and `cs_n`; `sdi` uses the synchronizer output only.

## Test plan

- Valid frame 05 0A 08 0F 05 05 00 00 00 00 14 → after `cs_n` rises: `sd0`…`sd5` = 5, 10, 8, 15, 5, 5; `clock_speed` = 20; `start` = 1; no `frame_err`.
- Byte 6 = 0xF0, remaining speed bytes 00 00 00 01 → `clock_speed` = 1 (upper nibble dropped).
- After a valid frame, send 80 bits → `start` falls at the `cs_n` falling edge, `frame_err` pulses once at the `cs_n` rising edge, `sd*`/`clock_speed` hold their previous values, `start` stays 0. Repeat with 96 bits → same response.
- Valid frame, then a second valid frame with `sd0` = 0x7F → `start` is low from the `cs_n` fall until commit, then high with `sd0` = 0x7F.
- Assert `reset_n` low after 40 bits → all outputs 0 immediately. A following full valid frame commits correctly.
- With `TUNE_SPI_ECHO_EN`: `sdo` during byte 1 = 0x05, during byte 2 = 0x0A. Without it: `sdo` = 0 throughout.
